// File: rtl/sdram_port_arb.sv
// Round-robin arbiter multiplexing NPORTS requesters onto a single-command SDRAM controller port.
// One command is outstanding at a time; a watchdog aborts a stuck ISSUE or RD_WAIT phase.
module sdram_port_arb #(
  parameter int NPORTS  = 4,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS-1:0]        req_write,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*16-1:0]     req_wdata,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        resp_valid,
  output logic [15:0]              resp_rdata,
  input  logic [NPORTS-1:0]        resp_ready,
  output logic                     m_cmd_valid,
  output logic                     m_cmd_write,
  output logic [ADDR_W-1:0]        m_cmd_addr,
  output logic [15:0]              m_cmd_wdata,
  input  logic                     m_cmd_ready,
  input  logic                     m_rsp_valid,
  input  logic [15:0]              m_rsp_rdata,
  output logic                     m_rsp_ready,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ARB     = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [1:0]        state;
  logic [2:0]        last_grant;
  logic [2:0]        owner;
  logic              hold_write;
  logic [ADDR_W-1:0] hold_addr;
  logic [15:0]       hold_wdata;
  logic [WD_W-1:0]   wdog;
  logic              err;

  logic              hi_found, any_req;
  logic [2:0]        hi_idx, lo_idx, sel;
  logic              sel_write, own_ready;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic              accept, cmd_hs, rsp_hs, wd_expire;

  function automatic logic [NPORTS-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (idx == 3'(i)) onehot[i] = 1'b1;
    end
  endfunction

  // Rotating priority: lowest requesting index above last_grant wins, else lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    any_req  = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        lo_idx  = 3'(i);
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    sel = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    own_ready = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel == 3'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*16 +: 16];
      end
      if (owner == 3'(i)) own_ready = resp_ready[i];
    end
  end

  assign accept    = (state == ARB) && any_req;
  assign cmd_hs    = (state == ISSUE) && m_cmd_ready;
  assign rsp_hs    = (state == RD_WAIT) && m_rsp_valid && own_ready;
  assign wd_expire = (state != ARB) && (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      last_grant <= 3'(NPORTS - 1);
      owner      <= '0;
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      wdog       <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          wdog <= '0;
          if (accept) begin
            hold_write <= sel_write;
            hold_addr  <= sel_addr;
            hold_wdata <= sel_wdata;
            owner      <= sel;
            last_grant <= sel;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_hs) begin
            wdog  <= '0;
            state <= hold_write ? ARB : RD_WAIT;
          end else if (wd_expire) begin
            wdog  <= '0;
            err   <= 1'b1;
            state <= ARB;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RD_WAIT: begin
          if (rsp_hs) begin
            wdog  <= '0;
            state <= ARB;
          end else if (wd_expire) begin
            wdog  <= '0;
            err   <= 1'b1;
            state <= ARB;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // req_ready is combinational, so it is masked while reset is held.
  assign req_ready   = (rst_n && accept) ? onehot(sel) : '0;
  assign resp_valid  = ((state == RD_WAIT) && m_rsp_valid) ? onehot(owner) : '0;
  assign m_rsp_ready = (state == RD_WAIT) ? own_ready : 1'b1;
  assign resp_rdata  = m_rsp_rdata;
  assign m_cmd_valid = (state == ISSUE);
  assign m_cmd_write = hold_write;
  assign m_cmd_addr  = hold_addr;
  assign m_cmd_wdata = hold_wdata;
  assign grant_id    = owner;
  assign busy        = (state != ARB);
  assign timeout_err = err;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: table of transactions plus timeout and reset sequences.
module tb_sdram_port_arb;

  localparam int NPORTS = 4;
  localparam int ADDR_W = 24;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NPORTS-1:0]        req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS*16-1:0]     req_wdata;
  logic [15:0]              resp_rdata, m_cmd_wdata, m_rsp_rdata;
  logic                     m_cmd_valid, m_cmd_write, m_cmd_ready;
  logic [ADDR_W-1:0]        m_cmd_addr;
  logic                     m_rsp_valid, m_rsp_ready, busy, timeout_err;
  logic [2:0]               grant_id;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] port_addr [NPORTS] = '{24'h0A0B0C, 24'h111111, 24'h000123, 24'h333333};
  logic [15:0]       port_data [NPORTS] = '{16'h1000, 16'h2001, 16'hBEEF, 16'h4003};

  typedef struct {
    logic [3:0]  valid;
    logic        wr;
    int          stall;
    int          rsp_stall;
    logic [15:0] rdata;
    int          exp_port;
  } txn_t;

  txn_t tbl [11];

  sdram_port_arb #(.NPORTS(NPORTS), .ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready),
    .m_cmd_valid(m_cmd_valid), .m_cmd_write(m_cmd_write), .m_cmd_addr(m_cmd_addr),
    .m_cmd_wdata(m_cmd_wdata), .m_cmd_ready(m_cmd_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_ready(m_rsp_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cmd_valid"}, 32'(m_cmd_valid), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_m_rsp_ready"}, 32'(m_rsp_ready), 1);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_cmd_addr"}, 32'(m_cmd_addr), 0);
  endtask

  // One complete transaction starting from an idle arbiter.
  task automatic serve(input logic [3:0] valid, input logic wr, input int stall,
                       input int rsp_stall, input logic [15:0] rdata, input int ep);
    logic [3:0] oh;
    oh = 4'b0001 << ep;
    req_valid = valid;
    req_write = {NPORTS{wr}};
    #1;
    check("arb_req_ready", 32'(req_ready), 32'(oh));
    check("arb_busy", 32'(busy), 0);
    tick;
    req_valid   = valid & ~oh;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 16'hDEAD;
    #1;
    check("issue_cmd_valid", 32'(m_cmd_valid), 1);
    check("issue_grant_id", 32'(grant_id), 32'(ep));
    check("issue_cmd_addr", 32'(m_cmd_addr), 32'(port_addr[ep]));
    check("issue_cmd_write", 32'(m_cmd_write), 32'(wr));
    check("issue_cmd_wdata", 32'(m_cmd_wdata), 32'(port_data[ep]));
    check("issue_req_ready", 32'(req_ready), 0);
    check("issue_stray_resp_valid", 32'(resp_valid), 0);
    check("issue_m_rsp_ready", 32'(m_rsp_ready), 1);
    check("issue_busy", 32'(busy), 1);
    for (int s = 0; s < stall; s++) begin
      tick;
      check("stall_cmd_valid", 32'(m_cmd_valid), 1);
      check("stall_cmd_addr", 32'(m_cmd_addr), 32'(port_addr[ep]));
      check("stall_cmd_wdata", 32'(m_cmd_wdata), 32'(port_data[ep]));
    end
    m_rsp_valid = 1'b0;
    m_cmd_ready = 1'b1;
    tick;
    m_cmd_ready = 1'b0;
    req_valid   = '0;
    #1;
    check("post_cmd_valid", 32'(m_cmd_valid), 0);
    check("post_resp_valid", 32'(resp_valid), 0);
    if (wr) begin
      check("wr_back_to_arb", 32'(busy), 0);
    end else begin
      check("rd_wait_busy", 32'(busy), 1);
      m_rsp_valid = 1'b1;
      m_rsp_rdata = rdata;
      resp_ready  = '0;
      for (int s = 0; s < rsp_stall; s++) begin
        #1;
        check("bp_resp_valid", 32'(resp_valid), 32'(oh));
        check("bp_resp_rdata", 32'(resp_rdata), 32'(rdata));
        check("bp_m_rsp_ready", 32'(m_rsp_ready), 0);
        tick;
      end
      resp_ready = oh;
      #1;
      check("rd_resp_valid", 32'(resp_valid), 32'(oh));
      check("rd_resp_rdata", 32'(resp_rdata), 32'(rdata));
      check("rd_m_rsp_ready", 32'(m_rsp_ready), 1);
      tick;
      m_rsp_valid = 1'b0;
      resp_ready  = '0;
      #1;
      check("rd_back_to_arb", 32'(busy), 0);
    end
  endtask

  initial begin
    tbl[0]  = '{4'hF, 1'b0, 0, 0, 16'h1111, 0};
    tbl[1]  = '{4'hE, 1'b0, 0, 0, 16'h2222, 1};
    tbl[2]  = '{4'hC, 1'b0, 0, 0, 16'h3333, 2};
    tbl[3]  = '{4'h8, 1'b0, 0, 0, 16'h4444, 3};
    tbl[4]  = '{4'h4, 1'b1, 5, 0, 16'h0000, 2};
    tbl[5]  = '{4'h9, 1'b0, 0, 0, 16'h5555, 3};
    tbl[6]  = '{4'h9, 1'b0, 0, 0, 16'h6666, 0};
    tbl[7]  = '{4'h2, 1'b1, 0, 0, 16'h0000, 1};
    tbl[8]  = '{4'hA, 1'b1, 0, 0, 16'h0000, 3};
    tbl[9]  = '{4'h2, 1'b1, 0, 0, 16'h0000, 1};
    tbl[10] = '{4'h1, 1'b0, 0, 3, 16'h5A5A, 0};

    for (int i = 0; i < NPORTS; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = port_addr[i];
      req_wdata[i*16 +: 16]        = port_data[i];
    end
    rst_n       = 1'b0;
    req_valid   = 4'hF;
    req_write   = '0;
    resp_ready  = '0;
    m_cmd_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = '0;
    tick;
    tick;
    check_reset_outputs("reset");
    req_valid = '0;
    rst_n     = 1'b1;
    tick;

    for (int t = 0; t < 11; t++) begin
      serve(tbl[t].valid, tbl[t].wr, tbl[t].stall, tbl[t].rsp_stall, tbl[t].rdata, tbl[t].exp_port);
    end

    // Watchdog: port 1 read never accepted by the controller.
    req_valid = 4'h2;
    req_write = '0;
    #1;
    check("to_req_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    for (int c = 1; c <= 16; c++) begin
      check("to_cmd_valid_held", 32'(m_cmd_valid), 1);
      check("to_err_not_yet", 32'(timeout_err), 0);
      tick;
    end
    check("to_err_set", 32'(timeout_err), 1);
    check("to_in_arb", 32'(busy), 0);
    check("to_cmd_dropped", 32'(m_cmd_valid), 0);
    serve(4'h4, 1'b1, 0, 0, 16'h0000, 2);
    check("to_err_sticky", 32'(timeout_err), 1);

    // Reset while port 3 waits for read data.
    req_valid = 4'h8;
    req_write = '0;
    tick;
    req_valid   = '0;
    m_cmd_ready = 1'b1;
    tick;
    m_cmd_ready = 1'b0;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 16'h7777;
    resp_ready  = '0;
    #1;
    check("pre_rst_resp_valid", 32'(resp_valid), 32'h8);
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick;
    m_rsp_valid = 1'b0;
    req_valid   = '0;
    rst_n       = 1'b1;
    tick;
    serve(4'hF, 1'b0, 0, 0, 16'h0F0F, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 4: number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 24: request address width, {row,col,bank} packing as used by the SDRAM controller.
REQ-003 SHALL have parameter TIMEOUT, default 4096: cycles allowed in ISSUE or RD_WAIT before abort.
REQ-004 SHALL have ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  NPORTS  per-port request valid.
req_write  in  NPORTS  per-port 1=write, 0=read.
req_addr  in  NPORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
req_wdata  in  NPORTS*16  per-port write data; port i at [i*16 +: 16].
req_ready  out  NPORTS  per-port request accepted.
resp_valid  out  NPORTS  per-port read data valid.
resp_rdata  out  16  read data, shared by all ports.
resp_ready  in  NPORTS  per-port read data consumed.
m_cmd_valid  out  1  command to the SDRAM controller.
m_cmd_write  out  1  command write flag.
m_cmd_addr  out  ADDR_W  command address.
m_cmd_wdata  out  16  command write data.
m_cmd_ready  in  1  controller accepts the command.
m_rsp_valid  in  1  controller read data valid.
m_rsp_rdata  in  16  controller read data.
m_rsp_ready  out  1  read data consumed.
grant_id  out  3  port currently owning the controller.
busy  out  1  arbiter not in ARB.
timeout_err  out  1  sticky abort flag.

Function
REQ-005 SHALL implement an FSM with three states: ARB, ISSUE, RD_WAIT.
REQ-006 In ARB, the arbiter SHALL select the first port with req_valid set, searching round-robin from (last_grant+1) mod NPORTS.
REQ-007 In ARB, req_ready SHALL be one-hot on the selected port in the same cycle (combinational); no req_ready bit SHALL be set in any other state.
REQ-008 On the req_valid&req_ready handshake, the arbiter SHALL latch write, addr, wdata and port index into holding registers, update last_grant, and enter ISSUE next cycle.
REQ-009 In ISSUE, m_cmd_valid SHALL be 1 and m_cmd_* SHALL be driven from the holding registers, stable until the handshake.
REQ-010 The m_cmd_valid&m_cmd_ready handshake SHALL move the FSM to ARB for a write, or to RD_WAIT for a read.
REQ-011 In RD_WAIT, resp_valid[owner] SHALL equal m_rsp_valid, m_rsp_ready SHALL equal resp_ready[owner], and all other resp_valid bits SHALL be 0.
REQ-012 In RD_WAIT, the m_rsp_valid&m_rsp_ready handshake SHALL return the FSM to ARB.
REQ-013 resp_rdata SHALL equal m_rsp_rdata combinationally.
REQ-014 Outside RD_WAIT, m_rsp_ready SHALL be 1 and all resp_valid SHALL be 0, so stray responses are drained.
REQ-015 Minimum turnaround SHALL be: ARB handshake in cycle N, m_cmd_valid in cycle N+1; at most one command outstanding at any time.
REQ-016 A watchdog counter SHALL clear on entry to ISSUE and to RD_WAIT, and SHALL increment each cycle spent in those states.
REQ-017 When the watchdog reaches TIMEOUT, the FSM SHALL go to ARB, drop the request, and set timeout_err; timeout_err SHALL clear only on reset.
REQ-018 grant_id SHALL hold the latched port index; busy SHALL be 1 in ISSUE and RD_WAIT.
REQ-019 A port deasserting req_valid without a handshake SHALL NOT be granted; requesters SHALL hold their request until req_ready.

Reset
REQ-020 Under reset, the arbiter SHALL be in state ARB, with last_grant=NPORTS-1 so port 0 has first priority.
REQ-021 Under reset, the holding registers, watchdog, grant_id and timeout_err SHALL be 0, as SHALL busy, m_cmd_valid, req_ready and resp_valid.
REQ-022 Under reset, m_rsp_ready SHALL be 1.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no response delivered.

Verification
REQ-024 Simultaneous requests: ports 0..3 all request reads at once from reset -> grants in order 0,1,2,3; each resp_valid returns only to its owner.
REQ-025 Write: port 2 writes addr 0x000123, data 0xBEEF; m_cmd_ready stalled 5 cycles -> m_cmd_* held stable for those cycles; ARB one cycle after the handshake; no resp_valid.
REQ-026 Fairness: port 1 requests back-to-back continuously while port 3 requests once -> port 3 is granted before the second port-1 grant.
REQ-027 Read backpressure: port 0 read returns 0x5A5A with resp_ready[0]=0 for 3 cycles -> resp_valid[0] and data held; m_rsp_ready=0 until resp_ready[0] rises.
REQ-028 Timeout with TIMEOUT=16: m_cmd_ready held 0 -> after 16 cycles in ISSUE, timeout_err=1, FSM in ARB, and the next request is served normally.
REQ-029 Reset mid-operation: rst_n asserted in RD_WAIT -> all outputs at their reset values; the first grant after reset goes to port 0.
